// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared constants and types for the note tone generator
//
// Purpose: note half-period table at 50 MHz, counter width and playback
//          state encoding shared by note_div_rom and note_tone_gen.
package piano_pkg;

  localparam int CNT_W     = 17;
  localparam int NUM_NOTES = 10;

  // Half-period in clocks for C4..E5 at 50 MHz (codes 0..9).
  localparam logic [CNT_W-1:0] NOTE_HALF [0:NUM_NOTES-1] = '{
    17'd95554, 17'd85132, 17'd75843, 17'd71586, 17'd63776,
    17'd56818, 17'd50619, 17'd47778, 17'd42566, 17'd37921
  };

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RELEASE
  } tone_state_t;

endpackage

// File: rtl/note_div_rom.sv
// rtl/note_div_rom.sv - note code to half-period lookup
//
// Purpose: combinational lookup of the half-period for a note code, scaled
//          down by DIV_SHIFT and clamped to a minimum of 2 clocks.
// Ports:
//   code  in   4      note code (codes >= NUM_NOTES give the minimum)
//   half  out  CNT_W  half-period in clocks, always >= 2
module note_div_rom
  import piano_pkg::*;
#(
  parameter int DIV_SHIFT = 0
) (
  input  logic [3:0]       code,
  output logic [CNT_W-1:0] half
);

  logic [CNT_W-1:0] raw;
  logic [CNT_W-1:0] shifted;

  always_comb begin
    raw = '0;
    if (code < 4'(NUM_NOTES)) begin
      raw = NOTE_HALF[code];
    end
    shifted = raw >> DIV_SHIFT;
    // A half-period below 2 would make the reload value underflow or
    // collapse the square wave, so large shifts saturate here.
    half = (shifted < CNT_W'(2)) ? CNT_W'(2) : shifted;
  end

endmodule

// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - square-wave tone generator driven by a note encoder
//
// Purpose: registers the encoder's note code and key flag, runs the playback
//          FSM and the half-period down-counter that produce a 50% duty tone.
// Optional: macro PIANO_SUSTAIN_EN adds a RELEASE state that keeps the tone
//           sounding for SUSTAIN_CYCLES clocks after the key is let go.
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset
//   Din        in   4  note code from the encoder
//   key_valid  in   1  high while any key is pressed
//   Dout       out  1  square-wave tone
//   Dnote      out  4  code of the note currently sounding
//   active     out  1  high while a tone is being generated
module note_tone_gen
  import piano_pkg::*;
#(
  parameter int DIV_SHIFT      = 0,
  parameter int SUSTAIN_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Din,
  input  logic       key_valid,
  output logic       Dout,
  output logic [3:0] Dnote,
  output logic       active
);

  logic [3:0]       Din_q;
  logic             kv_q;
  tone_state_t      state;
  tone_state_t      state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] half;
  logic             Dout_n;
  logic [3:0]       Dnote_n;
  logic             key_on;
  logic [3:0]       rom_code;

  // Out-of-range codes are indistinguishable from no key at all.
  assign key_on = kv_q && (Din_q < 4'(NUM_NOTES));

  // While a valid key is held the lookup follows the incoming code, so a
  // note change reloads with the new half-period on the same edge; otherwise
  // it follows the note already sounding.
  assign rom_code = key_on ? Din_q : Dnote;

  note_div_rom #(
    .DIV_SHIFT(DIV_SHIFT)
  ) u_rom (
    .code(rom_code),
    .half(half)
  );

`ifdef PIANO_SUSTAIN_EN
  localparam int SCNT_W = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;
  logic [SCNT_W-1:0] scnt;
  logic [SCNT_W-1:0] scnt_n;
`else
  logic unused_sustain;
  assign unused_sustain = (SUSTAIN_CYCLES != 0);
`endif

  assign active = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      Din_q <= '0;
      kv_q  <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      Dout  <= 1'b0;
      Dnote <= '0;
`ifdef PIANO_SUSTAIN_EN
      scnt  <= '0;
`endif
    end else begin
      Din_q <= Din;
      kv_q  <= key_valid;
      state <= state_n;
      cnt   <= cnt_n;
      Dout  <= Dout_n;
      Dnote <= Dnote_n;
`ifdef PIANO_SUSTAIN_EN
      scnt  <= scnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    Dout_n  = Dout;
    Dnote_n = Dnote;
`ifdef PIANO_SUSTAIN_EN
    scnt_n  = scnt;
`endif

    case (state)
      IDLE: begin
        Dout_n = 1'b0;
        if (key_on) begin
          state_n = PLAY;
          Dnote_n = Din_q;
          cnt_n   = half - CNT_W'(1);
        end
      end

      PLAY: begin
        if (!key_on) begin
`ifdef PIANO_SUSTAIN_EN
          state_n = RELEASE;
          scnt_n  = SCNT_W'(SUSTAIN_CYCLES - 1);
          if (cnt == '0) begin
            Dout_n = ~Dout;
            cnt_n  = half - CNT_W'(1);
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
`else
          state_n = IDLE;
          Dout_n  = 1'b0;
`endif
        end else if (Din_q != Dnote) begin
          // Restart the phase cleanly on the new note.
          Dnote_n = Din_q;
          cnt_n   = half - CNT_W'(1);
          Dout_n  = 1'b0;
        end else if (cnt == '0) begin
          Dout_n = ~Dout;
          cnt_n  = half - CNT_W'(1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

`ifdef PIANO_SUSTAIN_EN
      RELEASE: begin
        if (key_on) begin
          // A fresh press always restarts, even on the same note.
          state_n = PLAY;
          Dnote_n = Din_q;
          cnt_n   = half - CNT_W'(1);
          Dout_n  = 1'b0;
        end else if (scnt == '0) begin
          state_n = IDLE;
          Dout_n  = 1'b0;
        end else begin
          scnt_n = scnt - SCNT_W'(1);
          if (cnt == '0) begin
            Dout_n = ~Dout;
            cnt_n  = half - CNT_W'(1);
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
      end
`endif

      default: begin
        state_n = IDLE;
        Dout_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// tb/tb_note_tone_gen.sv - scoreboard bench for note_tone_gen
module tb_note_tone_gen;

  localparam int SUSTAIN = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] Din;
  logic       dout_a, active_a, dout_b, active_b;
  logic [3:0] dnote_a, dnote_b;

  always #5 clk = ~clk;

  note_tone_gen #(.DIV_SHIFT(10), .SUSTAIN_CYCLES(SUSTAIN)) dut_a (
    .clk(clk), .rst(rst), .Din(Din), .key_valid(key_valid),
    .Dout(dout_a), .Dnote(dnote_a), .active(active_a)
  );

  note_tone_gen #(.DIV_SHIFT(17), .SUSTAIN_CYCLES(SUSTAIN)) dut_b (
    .clk(clk), .rst(rst), .Din(Din), .key_valid(key_valid),
    .Dout(dout_b), .Dnote(dnote_b), .active(active_b)
  );

  typedef struct {
    bit playing;
    bit releasing;
    int note;
    int t0;
    int rel_t0;
    bit kv_q;
    int din_q;
  } model_t;

  typedef struct {
    bit dout;
    int dnote;
    bit active;
  } exp_t;

  int note_table [10] = '{95554, 85132, 75843, 71586, 63776,
                          56818, 50619, 47778, 42566, 37921};

  int     n_total = 0;
  int     n_pass  = 0;
  int     edge_n  = 0;
  model_t ma = '{default: 0};
  model_t mb = '{default: 0};
  exp_t   q_a[$];
  exp_t   q_b[$];
  int     rises[$];
  int     falls[$];
  bit     prev_dout_a = 1'b0;

  function automatic int half_of(int code, int shift);
    int h;
    h = note_table[code] >> shift;
    return (h < 2) ? 2 : h;
  endfunction

  // Behaviour at edge n given the inputs registered on the previous edge.
  function automatic model_t step(model_t m, bit r, bit kv, int din, int n);
    model_t s;
    bit     key_on;
    s = m;
    if (r) begin
      s = '{default: 0};
      return s;
    end
    key_on = m.kv_q && (m.din_q < 10);
    if (!s.playing) begin
      if (key_on) begin
        s.playing = 1; s.note = m.din_q; s.t0 = n; s.releasing = 0;
      end
    end else if (key_on) begin
      if (m.din_q != s.note || s.releasing) begin
        s.note = m.din_q; s.t0 = n; s.releasing = 0;
      end
    end else begin
`ifdef PIANO_SUSTAIN_EN
      if (!s.releasing) begin
        s.releasing = 1; s.rel_t0 = n;
      end else if (n - s.rel_t0 == SUSTAIN) begin
        s.playing = 0; s.releasing = 0;
      end
`else
      s.playing = 0;
`endif
    end
    s.kv_q  = kv;
    s.din_q = din;
    return s;
  endfunction

  function automatic exp_t expect_of(model_t s, int n, int shift);
    exp_t e;
    e.active = s.playing;
    e.dnote  = s.note;
    e.dout   = s.playing ? (((n - s.t0) / half_of(s.note, shift)) % 2 == 1) : 1'b0;
    return e;
  endfunction

  task automatic chk(string name, int got, int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, got, want);
  endtask

  task automatic chk_out(string name, exp_t e, logic d, logic [3:0] dn, logic a);
    n_total++;
    if ({d, dn, a} === {e.dout, 4'(e.dnote), e.active}) n_pass++;
    else $display("FAIL %s at edge %0d: got dout=%b dnote=%0d active=%b, expected dout=%0b dnote=%0d active=%0b",
                  name, edge_n, d, dn, a, e.dout, e.dnote, e.active);
  endtask

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: issues the expected outputs for every edge.
  initial forever begin
    @(posedge clk);
    edge_n++;
    ma = step(ma, rst, key_valid, int'(Din), edge_n);
    mb = step(mb, rst, key_valid, int'(Din), edge_n);
    q_a.push_back(expect_of(ma, edge_n, 10));
    q_b.push_back(expect_of(mb, edge_n, 17));
  end

  // Monitor: compares the DUT outputs against queued expectations.
  initial forever begin
    exp_t e;
    @(negedge clk);
    while (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk_out("tone_shift10", e, dout_a, dnote_a, active_a);
    end
    while (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk_out("tone_shift17", e, dout_b, dnote_b, active_b);
    end
    if (dout_a === 1'b1 && !prev_dout_a) rises.push_back(edge_n);
    if (dout_a === 1'b0 && prev_dout_a) falls.push_back(edge_n);
    prev_dout_a = (dout_a === 1'b1);
  end

  initial begin
    int e0, e1, ed, ep, w;
    rst = 1'b1; key_valid = 1'b1; Din = 4'd5;

    // Reset held with a key pressed, then PLAY two edges after release.
    run(3);
    rst = 1'b0;
    run(1);
    chk("rst_exit_edge1_active", int'(active_a), 0);
    run(1);
    chk("rst_exit_edge2_active", int'(active_a), 1);
    key_valid = 1'b0;
    run(10);

    // Single note, code 5 (HALF 55).
    rises.delete(); falls.delete();
    e0 = edge_n; key_valid = 1'b1; Din = 4'd5;
    run(299);
    chk("single_rise_count", int'(rises.size() >= 2), 1);
    chk("single_rise0", (rises.size() > 0) ? rises[0] - e0 : -1, 57);
    chk("single_fall0", (falls.size() > 0) ? falls[0] - e0 : -1, 112);
    chk("single_rise1", (rises.size() > 1) ? rises[1] - e0 : -1, 167);

    // Note change to code 9 (HALF 37).
    rises.delete();
    e1 = edge_n; Din = 4'd9;
    run(2);
    chk("change_dnote", int'(dnote_a), 9);
    chk("change_dout_forced", int'(dout_a), 0);
    run(200);
    chk("change_rise0", (rises.size() > 0) ? rises[0] - e1 : -1, 39);
    chk("change_period", (rises.size() > 1) ? rises[1] - rises[0] : -1, 74);

    // Release while the tone is high, then re-press on code 0 (HALF 93).
    w = 0;
    while (dout_a !== 1'b1 && w < 500) begin run(1); w++; end
    chk("wait_dout_high", int'(dout_a === 1'b1), 1);
    ed = edge_n; key_valid = 1'b0;
    run(1);
    chk("release_edge1_active", int'(active_a), 1);
    run(1);
`ifndef PIANO_SUSTAIN_EN
    chk("release_edge2_active", int'(active_a), 0);
    chk("release_edge2_dout", int'(dout_a), 0);
`endif
    run(8);
    rises.delete();
    ep = edge_n; key_valid = 1'b1; Din = 4'd0;
    run(200);
    chk("repress_rise0", (rises.size() > 0) ? rises[0] - ep : -1, 95);

`ifdef PIANO_SUSTAIN_EN
    // Sustain tail: active for SUSTAIN clocks after release.
    ed = edge_n; key_valid = 1'b0;
    run(201);
    chk("sustain_still_active", int'(active_a), 1);
    run(1);
    chk("sustain_end_active", int'(active_a), 0);
    chk("sustain_end_dout", int'(dout_a), 0);
    key_valid = 1'b1; Din = 4'd0;
    run(150);
    key_valid = 1'b0;
    run(100);
    key_valid = 1'b1; Din = 4'd3;
    run(100);
`endif

    // Invalid code from idle.
    key_valid = 1'b0;
    run(SUSTAIN + 10);
    key_valid = 1'b1; Din = 4'd12;
    run(50);
    chk("invalid_active", int'(active_a), 0);
    chk("invalid_dout", int'(dout_a), 0);

    // Randomized segments, occasionally with reset.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        run($urandom_range(1, 3));
        rst = 1'b0;
      end
      key_valid = ($urandom_range(0, 3) != 0);
      Din = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      run($urandom_range(1, 250));
    end

    key_valid = 1'b0;
    run(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Downstream consumer of the 10-key decimal-to-binary note encoder. Takes its 4-bit note code plus a key-pressed flag and produces a 50%-duty square-wave tone for the buzzer/speaker pin.
- Notes are C4..E5: code 0=C4, 1=D4, 2=E4, 3=F4, 4=G4, 5=A4, 6=B4, 7=C5, 8=D5, 9=E5.
- Contains input registering, a playback FSM and a programmable half-period down-counter.

Parameters:
- DIV_SHIFT, 0, right-shift applied to every half-period table entry. Used for simulation speed-up; 0 in silicon.
- SUSTAIN_CYCLES, 25_000_000, release-tail length in clocks. Used only when PIANO_SUSTAIN_EN is defined.

Ports:
- clk  input  1  system clock, 50 MHz nominal; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- Din  input  4  note code from the encoder
- key_valid  input  1  high while any key is pressed (OR of all key lines)
- Dout  output  1  square-wave tone
- Dnote  output  4  code of the note currently sounding
- active  output  1  high while a tone is being generated

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: Dout=0, Dnote=0, active=0, FSM=IDLE, counter=0, input registers=0.
- Input stage: Din and key_valid are registered once (Din_q, kv_q) at every edge. Codes 10..15 are treated as kv_q=0 (silence).
- Half-period lookup: HALF = max(NOTE_HALF[Dnote] >> DIV_SHIFT, 2).
- NOTE_HALF at 50 MHz, codes 0..9: 95554, 85132, 75843, 71586, 63776, 56818, 50619, 47778, 42566, 37921.
- Counter width is 17 bits.
- FSM IDLE:
  - Dout=0, active=0.
  - On kv_q=1 and a valid code: latch Dnote=Din_q, load cnt=HALF-1, Dout=0, go to PLAY.
- FSM PLAY:
  - active=1.
  - Each cycle: if cnt==0, toggle Dout and reload cnt=HALF-1; otherwise decrement cnt.
  - Resulting tone period is exactly 2*HALF cycles.
- Note change in PLAY (kv_q=1, Din_q != Dnote): same cycle, latch the new Dnote, reload cnt with the new HALF-1, force Dout=0. Phase restarts and there is no partial half-period.
- Key release in PLAY (kv_q=0): next edge goes to IDLE, Dout=0, active=0. Dnote holds its last value.
- Latency: key asserted before edge k → kv_q at edge k → PLAY entered, cnt loaded at edge k+1 → first rising Dout at edge k+1+HALF.
- Simultaneous release and code change: release wins.
- rst mid-tone: all state returns to reset values on that edge. There is no glitch beyond a truncated half-period.

Optional Feature:
- Macro PIANO_SUSTAIN_EN.
- Defined:
  - Adds a RELEASE state. Key release in PLAY enters RELEASE with scnt=SUSTAIN_CYCLES-1.
  - The tone continues at Dnote and active stays 1. scnt decrements each cycle; at scnt==0, go to IDLE with Dout=0.
  - A new valid key press in RELEASE acts as a note change and returns to PLAY.
  - rst clears scnt.
- Not defined: no RELEASE state and no scnt register; release goes directly to IDLE as above.

Decomposition:
- piano_pkg:
  - CNT_W=17
  - NOTE_HALF[0:9] constant array
  - NUM_NOTES=10
  - typedef enum tone_state_t {IDLE, PLAY, RELEASE}
- Sub-module note_div_rom: combinational code → HALF lookup, including DIV_SHIFT and the clamp to ≥2.
- The FSM and counter stay in note_tone_gen.

Test Plan (DIV_SHIFT=10 unless noted; code 5 → HALF=55, code 0 → HALF=93, code 9 → HALF=37):
- Reset: hold rst 3 cycles with key_valid=1, Din=5 → Dout=0, active=0, Dnote=0 throughout. After release, PLAY begins 2 edges later.
- Single note: key_valid=1, Din=5 from edge 0 → active=1 at edge 2. Dout rises at edge 57, falls at 112, rises at 167 (period 110).
- Note change: hold Din=5 for 300 cycles, then Din=9 → Dnote=9 one edge after kv_q/Din_q update, Dout forced 0. Next rise 37 cycles later; period 74.
- Release: drop key_valid mid-high-phase → Dout=0 and active=0 two edges after the drop. A re-press restarts with the full first half-period.
- Invalid code: Din=12, key_valid=1 → stays IDLE, Dout=0. Also check DIV_SHIFT=17 → HALF clamps to 2, period 4.
- PIANO_SUSTAIN_EN with SUSTAIN_CYCLES=200: release during code 0 → tone continues, active=1 for 200 cycles, then IDLE. A re-press at cycle 100 of release returns to PLAY.
